// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the bit-serial adder.
interface serial_adder_if #(
   parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sum;
   logic             C_out;

   modport master (
      output start, A, B, C_in,
      input  busy, done, Sum, C_out
   );

   modport slave (
      input  start, A, B, C_in,
      output busy, done, Sum, C_out
   );
endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell used as the arithmetic stage of the serial adder.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic C_in,
   output logic Sum,
   output logic C_out
);
   assign Sum   = A ^ B ^ C_in;
   assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry kept in a flop.
// A result appears WIDTH cycles after the accepting edge; DONE may accept a new start.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] sa_reg, sb_reg, res_reg, sum_reg;
   logic             carry_reg, cout_reg;
   logic [CW-1:0]    cnt_reg;
   logic             fa_sum, fa_cout;
   logic             accept, last_bit;
   logic             busy, done;

   assign accept   = bus.start && (state_reg == IDLE || state_reg == DONE);
   assign last_bit = (cnt_reg == LAST);

   full_adder u_fa (
      .A     (sa_reg[0]),
      .B     (sb_reg[0]),
      .C_in  (carry_reg),
      .Sum   (fa_sum),
      .C_out (fa_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (accept) state_next = ADD;
         ADD:     if (last_bit) state_next = DONE;
         DONE:    state_next = accept ? ADD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_reg)
         ADD:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Operands are captured only on accept, so later input changes cannot disturb a run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_reg    <= '0;
         sb_reg    <= '0;
         res_reg   <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else if (accept) begin
         sa_reg    <= bus.A;
         sb_reg    <= bus.B;
         carry_reg <= bus.C_in;
         cnt_reg   <= '0;
      end else if (state_reg == ADD) begin
         sa_reg    <= sa_reg >> 1;
         sb_reg    <= sb_reg >> 1;
         res_reg   <= {fa_sum, res_reg[WIDTH-1:1]};
         carry_reg <= fa_cout;
         if (last_bit) begin
            sum_reg  <= {fa_sum, res_reg[WIDTH-1:1]};
            cout_reg <= fa_cout;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.Sum   = sum_reg;
   assign bus.C_out = cout_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8.
module tb_serial_adder;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Issue one operation, scramble inputs after acceptance, wait (bounded) for done.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         output logic [7:0] s, output logic co,
                         output int lat, output int busy_cnt);
      bus.A = a; bus.B = b; bus.C_in = c; bus.start = 1'b1;
      lat = 0; busy_cnt = 0; s = 'x; co = 1'bx;
      while (lat <= 40) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.start = 1'b0;
            bus.A     = 8'($urandom);
            bus.B     = 8'($urandom);
            bus.C_in  = 1'($urandom);
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            s  = bus.Sum;
            co = bus.C_out;
            break;
         end
      end
      lat = lat - 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.C_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.C_out, bus.Sum} !== 11'd0)
         $display("FAIL reset_state: got busy=%b done=%b c_out=%b sum=%h, need all 0",
                  bus.busy, bus.done, bus.C_out, bus.Sum);
         else $display("reset: outputs 0");
      if ({bus.busy, bus.done, bus.C_out, bus.Sum} !== 11'd0) errors++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] s; logic co; int lat, bc;
      run_op(8'h5A, 8'h3C, 1'b0, s, co, lat, bc);
      $display("op 5a+3c+0 -> sum=%h c_out=%b latency=%0d busy=%0d", s, co, lat, bc);
      checks++; if (s !== 8'h96) begin errors++; $display("FAIL basic_sum: got %h need 96", s); end
      checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b need 0", co); end
      checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d need 8", lat); end
      checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d need 8", bc); end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Sum !== 8'h96) begin
         errors++;
         $display("FAIL basic_after_done: got done=%b busy=%b sum=%h need 0 0 96",
                  bus.done, bus.busy, bus.Sum);
      end
   endtask

   task automatic test_carry();
      logic [7:0] ta [2] = '{8'hFF, 8'hFF};
      logic [7:0] tb [2] = '{8'h01, 8'hFF};
      logic       tc [2] = '{1'b0, 1'b1};
      logic [7:0] ts [2] = '{8'h00, 8'hFF};
      logic [7:0] s; logic co; int lat, bc;
      for (int i = 0; i < 2; i++) begin
         run_op(ta[i], tb[i], tc[i], s, co, lat, bc);
         $display("op %h+%h+%b -> sum=%h c_out=%b", ta[i], tb[i], tc[i], s, co);
         checks++;
         if ({co, s} !== {1'b1, ts[i]}) begin
            errors++;
            $display("FAIL carry_%0d: got %b_%h need 1_%h", i, co, s, ts[i]);
         end
      end
   endtask

   task automatic test_start_ignored();
      int         ndone = 0;
      logic [7:0] s = '0;
      bus.A = 8'h10; bus.B = 8'h20; bus.C_in = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.A = 8'h77; bus.B = 8'h55; bus.C_in = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done) begin ndone++; s = bus.Sum; end
         @(negedge clk);
      end
      $display("op 10+20 with start during ADD -> sum=%h dones=%0d", s, ndone);
      checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d need 1", ndone); end
      checks++; if (s !== 8'h30) begin errors++; $display("FAIL ignore_sum: got %h need 30", s); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: got busy=%b need 0", bus.busy); end
   endtask

   task automatic test_reset_abort();
      int ndone = 0;
      logic [7:0] s; logic co; int lat, bc;
      bus.A = 8'h0F; bus.B = 8'h01; bus.C_in = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.C_out, bus.Sum} !== 11'd0) begin
         errors++;
         $display("FAIL abort_outputs: got busy=%b done=%b c_out=%b sum=%h need all 0",
                  bus.busy, bus.done, bus.C_out, bus.Sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d need 0", ndone); end
      run_op(8'h0F, 8'h01, 1'b0, s, co, lat, bc);
      $display("op 0f+01 after reset -> sum=%h c_out=%b", s, co);
      checks++;
      if ({co, s} !== 9'h010) begin errors++; $display("FAIL abort_rerun: got %b_%h need 0_10", co, s); end
   endtask

   task automatic test_back_to_back();
      int ndone = 0, cyc = 0, last = -1;
      bus.A = 8'h01; bus.B = 8'h01; bus.C_in = 1'b0; bus.start = 1'b1;
      while (cyc < 80 && ndone < 5) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            ndone++;
            $display("b2b op 01+01 -> sum=%h c_out=%b cycle=%0d", bus.Sum, bus.C_out, cyc);
            checks++;
            if ({bus.C_out, bus.Sum} !== 9'h002) begin
               errors++;
               $display("FAIL b2b_sum: got %b_%h need 0_02", bus.C_out, bus.Sum);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last !== 9) begin
                  errors++;
                  $display("FAIL b2b_interval: got %0d need 9", cyc - last);
               end
            end
            last = cyc;
         end
      end
      bus.start = 1'b0;
      checks++; if (ndone !== 5) begin errors++; $display("FAIL b2b_count: got %0d need 5", ndone); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0] a, b, s; logic c, co; int lat, bc;
      logic [8:0] exp_v;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
         exp_v = 9'(a) + 9'(b) + 9'(c);
         run_op(a, b, c, s, co, lat, bc);
         $display("rnd %0d: %h+%h+%b -> %b_%h", i, a, b, c, co, s);
         checks++;
         if ({co, s} !== exp_v || lat !== 8) begin
            errors++;
            $display("FAIL random_%0d: got %b_%h latency %0d need %b_%h latency 8",
                     i, co, s, lat, exp_v[8], exp_v[7:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
